// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU and a DMA/loader.
// Optional DMA starvation guard is compiled in with `define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_t;

  state_t            state_q, state_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              dma_rd_q, dma_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_win, dma_win;
  logic              force_dma;

  // An out-of-range limit shows up as this named block in the elaborated hierarchy.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign force_dma = (starve_q == LIMIT);

  always_comb begin
    starve_d = '0;
    if (dma_req && !dma_gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  // A held lock beats everything, including a forced DMA grant.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (state_q == OWN_CPU && cpu_req && cpu_lock) begin
      cpu_win = 1'b1;
    end else if (state_q == OWN_DMA && dma_req && dma_lock) begin
      dma_win = 1'b1;
    end else if (force_dma && dma_req) begin
      dma_win = 1'b1;
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end else if (dma_req) begin
      dma_win = 1'b1;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (cpu_win && cpu_lock) begin
      state_d = OWN_CPU;
    end else if (dma_win && dma_lock) begin
      state_d = OWN_DMA;
    end
    cpu_rd_d = cpu_win && !cpu_we;
    dma_rd_d = dma_win && !dma_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cpu_rd_q <= 1'b0;
      dma_rd_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cpu_rd_q <= cpu_rd_d;
      dma_rd_q <= dma_rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Grants and write enable are forced low while reset is asserted.
  assign cpu_gnt    = cpu_win & reset;
  assign dma_gnt    = dma_win & reset;
  assign mem_we     = reset & ((cpu_win & cpu_we) | (dma_win & dma_we));
  assign mem_addr   = dma_win ? dma_addr  : (cpu_win ? cpu_addr  : addr_q);
  assign mem_wdata  = dma_win ? dma_wdata : (cpu_win ? cpu_wdata : wdata_q);
  assign cpu_rvalid = cpu_rd_q;
  assign dma_rvalid = dma_rd_q;
  assign rdata      = mem_rdata;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the microcontroller's single-port 8-bit data memory between the CPU datapath (driven by the control unit's MAR/write sequencing) and a DMA/program-loader requester. It accepts at most one access per cycle and routes address, write data and write enable to the memory. It returns read data with a one-cycle valid strobe to the winning requester. Locked sequences let either requester hold the port across multi-cycle operations such as read-modify-write.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- STARVE_LIMIT, 4, consecutive lost DMA cycles before a forced DMA grant (guard build only), range 1–15

- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, level
- cpu_we  input  1  1 = write, 0 = read
- cpu_lock  input  1  hold port after grant while high with cpu_req
- cpu_addr  input  ADDR_W  access address
- cpu_wdata  input  DATA_W  write data
- cpu_gnt  output  1  access accepted this cycle
- cpu_rvalid  output  1  read data valid for CPU
- dma_req, dma_we, dma_lock, dma_addr, dma_wdata  input  1/1/1/ADDR_W/DATA_W  same meaning for DMA
- dma_gnt, dma_rvalid  output  1/1  same meaning for DMA
- rdata  output  DATA_W  read data, shared; qualified by *_rvalid
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_we  output  1  memory write enable, sampled at posedge
- mem_rdata  input  DATA_W  memory read data, one cycle after address
- busy  output  1  a lock is held (state ≠ IDLE)

## Operation
- FSM states: IDLE, OWN_CPU, OWN_DMA. Reset → IDLE.
- IDLE arbitration, same cycle, combinational:
  - Forced DMA grant takes precedence when active (guard build).
  - Otherwise CPU wins whenever cpu_req=1.
  - DMA wins only when cpu_req=0.
- Winner with lock=1 → next state OWN_<winner>.
- OWN_x:
  - While x_req && x_lock, x wins every cycle and the other requester is refused, including a forced grant.
  - When x drops req or lock, that cycle is arbitrated as in IDLE. Next state is IDLE, or OWN_<winner> if the winner is locked.
- Exactly one of cpu_gnt/dma_gnt is high per cycle, or neither.
- A gnt is only high when the matching req is high.
- Requesters hold addr/we/wdata stable until they sample gnt=1.
- Winner's addr/wdata/we drive mem_*. With no winner: mem_we=0, mem_addr/mem_wdata hold their last values.
- A granted read registers a read tag. The next cycle asserts that requester's rvalid for exactly one cycle, with rdata=mem_rdata.
- Back-to-back reads by the same or different requesters pipeline at one per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (memory write-first at posedge).
- A granted write produces no rvalid.
- During reset all gnt=0, rvalid=0, mem_we=0, busy=0, read tag cleared, starvation counter=0.
- Reset asserted mid-operation:
  - A pending rvalid is dropped.
  - A held lock is released.
  - After reset deasserts, arbitration restarts from IDLE.

## Timing
- Grant latency 0 cycles: gnt is in the same cycle as req when the requester wins.
- Write lands at the posedge closing the grant cycle.
- Read latency 1 cycle: rvalid/rdata are on the cycle after gnt.
- Peak throughput 1 access/cycle.
- All FSM, counter and rvalid state updates on posedge clk. Asynchronous clear on reset low.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and no CPU lock is held, DMA wins the next arbitration regardless of cpu_req.
  - The counter clears on dma_gnt or when dma_req=0.
- MEM_ARB_STARVE_GUARD_EN undefined:
  - Strict CPU priority; no counter logic.
  - DMA may starve indefinitely under continuous CPU requests.

## Test plan
- Read: memory[0x10]=0x5A; CPU reads 0x10 → cpu_gnt same cycle; next cycle cpu_rvalid=1, rdata=0x5A, dma_rvalid=0.
- Contention: cpu_req=dma_req=1 (CPU reads 0x01, DMA writes 0x33 to 0x02) → cpu_gnt=1, dma_gnt=0. CPU drops req next cycle → dma_gnt=1; memory[0x02]=0x33 after that edge.
- Write/readback: DMA writes 0xC3 to 0x40, then CPU reads 0x40 the following cycle → cpu_rvalid with rdata=0xC3.
- Lock: DMA locked writes 0xA0/0xA1/0xA2 to 0x20–0x22; CPU requests during the 2nd write → cpu_gnt=0 and busy=1 until dma_lock drops; CPU then granted in the cycle DMA releases.
- Starvation, guard defined, STARVE_LIMIT=4: CPU and DMA request continuously → dma_gnt=1 on the 5th cycle, then CPU resumes. Guard undefined: dma_gnt stays 0 over 20 cycles.
- Reset: CPU read granted, reset pulsed low the next cycle → cpu_rvalid=0, busy=0, state IDLE. The first request after reset is granted normally.
